// File: rtl/div_sequencer.sv
// div_sequencer
//   Buffers operand pairs in a small FIFO and feeds them one at a time to an
//   external multi-cycle divider. It pulses div_start, waits for the divider
//   to report completion (or gives up after TIMEOUT cycles), then holds the
//   captured quotient and status until the consumer takes it.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid/in_ready        operand push handshake; in_a dividend, in_b divisor
//   div_start, div_a, div_b  one-cycle start pulse and held operands to divider
//   div_q, div_busy          divider quotient and busy indication
//   div_valid/dvz/ovf        divider completion flags (sampled only while waiting)
//   out_valid/out_ready      result handshake; out_q quotient, out_status code
//                            (00 ok, 01 divide-by-zero, 10 overflow, 11 timeout)
//   fifo_level               current FIFO occupancy
module div_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 31
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [9:0]               in_a,
  input  logic [9:0]               in_b,
  output logic                     div_start,
  output logic [9:0]               div_a,
  output logic [9:0]               div_b,
  input  logic [9:0]               div_q,
  input  logic                     div_busy,
  input  logic                     div_valid,
  input  logic                     div_dvz,
  input  logic                     div_ovf,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [9:0]               out_q,
  output logic [1:0]               out_status,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int DATA_W = 10;
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [AW:0]   FULL_LVL   = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] TO_CNT     = CW'(TIMEOUT);
  localparam logic [1:0]    ST_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  // Divide-by-zero outranks overflow when the divider raises both at once.
  function automatic logic [1:0] status_enc(input logic dvz, input logic ovf);
    logic [1:0] st;
    if (dvz)      st = 2'b01;
    else if (ovf) st = 2'b10;
    else          st = 2'b00;
    return st;
  endfunction

  state_t state_q, state_d;

  logic [DATA_W-1:0] mem_a [DEPTH];
  logic [DATA_W-1:0] mem_b [DEPTH];

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       level_q,  level_d;
  logic [DATA_W-1:0] opa_q,    opa_d;
  logic [DATA_W-1:0] opb_q,    opb_d;
  logic [CW-1:0]     cnt_q,    cnt_d;
  logic [DATA_W-1:0] res_q,    res_d;
  logic [1:0]        st_q,     st_d;

  logic push;
  logic pop;
  logic launch;
  logic done_evt;
  logic timed_out;

  assign push      = in_valid && in_ready;
  // A new operation may start only when something is queued and the
  // divider has finished with the previous one.
  assign launch    = (level_q != '0) && !div_busy;
  assign done_evt  = div_valid || div_dvz || div_ovf;
  assign timed_out = (cnt_q == TO_CNT);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; pop marks the edge on which the FIFO head is
  // transferred into the divider operand registers.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (launch) begin
          state_d = S_ISSUE;
          pop     = 1'b1;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        // A completion arriving on the timeout cycle is still a normal finish.
        if (done_evt || timed_out) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          if (launch) begin
            state_d = S_ISSUE;
            pop     = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready   = (level_q != FULL_LVL);
    fifo_level = level_q;
    div_start  = (state_q == S_ISSUE);
    div_a      = opa_q;
    div_b      = opb_q;
    out_valid  = (state_q == S_HOLD);
    out_q      = res_q;
    out_status = st_q;
  end

  // FIFO storage carries no reset; only occupancy and pointers define content.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr_q] <= in_a;
      mem_b[wr_ptr_q] <= in_b;
    end
  end

  // FIFO pointers, operand registers, wait counter and result capture.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    st_d     = st_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      opa_d    = mem_a[rd_ptr_q];
      opb_d    = mem_b[rd_ptr_q];
    end
    if (push && !pop)      level_d = level_q + (AW+1)'(1);
    else if (!push && pop) level_d = level_q - (AW+1)'(1);

    case (state_q)
      S_ISSUE: cnt_d = '0;
      S_WAIT: begin
        if (done_evt) begin
          res_d = div_q;
          st_d  = status_enc(div_dvz, div_ovf);
        end else if (timed_out) begin
          res_d = '0;
          st_d  = ST_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      st_q     <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      st_q     <= st_d;
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer
//   Self-checking bench for div_sequencer: a table of single transactions with
//   hand-computed results, hand-written corner sequences (timeout, flag
//   priority, FIFO full, back-to-back issue, reset mid-operation), and a
//   randomized phase scored against a queue of expected results.
module tb_div_sequencer;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 31;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] in_a, in_b;
  logic       div_start;
  logic [9:0] div_a, div_b;
  logic [9:0] div_q;
  logic       div_busy, div_valid, div_dvz, div_ovf;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_q;
  logic [1:0] out_status;
  logic [$clog2(DEPTH):0] fifo_level;

  always #5 clk = ~clk;

  div_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_q(div_q), .div_busy(div_busy), .div_valid(div_valid),
    .div_dvz(div_dvz), .div_ovf(div_ovf),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_q(out_q), .out_status(out_status), .fifo_level(fifo_level)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- divider behaviour ----------------
  // mode 0: normal, 1: raises dvz and ovf together, 2: never responds
  int m_mode = 0;
  int m_lat  = 3;
  int inj_req = 0;
  int inj_done = 0;

  // Returns {dvz, ovf, q}. Overflow stands for a quotient that does not fit a
  // signed 10-bit result (divisor 1 with dividend >= 512).
  function automatic logic [11:0] div_model(input logic [9:0] a, input logic [9:0] b, input int mode);
    logic [9:0] q;
    logic dvz, ovf;
    q   = (b == 10'd0) ? 10'h3FF : a / b;
    dvz = (b == 10'd0) || (mode == 1);
    ovf = (b == 10'd1 && a >= 10'd512) || (mode == 1);
    return {dvz, ovf, q};
  endfunction

  // Returns {status, q} the sequencer should report for this operand pair.
  function automatic logic [11:0] expect_res(input logic [9:0] a, input logic [9:0] b, input int mode);
    logic [11:0] r;
    logic [1:0] st;
    if (mode == 2) return {2'b11, 10'd0};
    r  = div_model(a, b, mode);
    st = r[11] ? 2'b01 : (r[10] ? 2'b10 : 2'b00);
    return {st, r[9:0]};
  endfunction

  initial begin : divider_model
    logic [9:0] ma, mb;
    int mcnt, mmode;
    logic [11:0] r;
    div_busy = 0; div_valid = 0; div_dvz = 0; div_ovf = 0; div_q = '0;
    ma = '0; mb = '0; mcnt = 0; mmode = 0;
    forever begin
      @(posedge clk); #1;
      div_valid = 0; div_dvz = 0; div_ovf = 0;
      div_q = 10'($urandom);
      if (!rst_n) begin
        div_busy = 0;
      end else begin
        if (inj_req != inj_done) begin
          inj_done = inj_req;
          div_valid = 1; div_dvz = 1; div_ovf = 1;
        end
        if (div_start && m_mode != 2) begin
          ma = div_a; mb = div_b; mcnt = m_lat; mmode = m_mode;
          div_busy = 1;
        end else if (div_busy) begin
          mcnt--;
          if (mcnt == 0) begin
            r = div_model(ma, mb, mmode);
            div_busy  = 0;
            div_q     = r[9:0];
            div_dvz   = r[11];
            div_ovf   = r[10];
            div_valid = !(r[11] | r[10]);
          end
        end
      end
    end
  end

  // ---------------- monitor ----------------
  int cyc = 0;
  int start_cnt = 0;
  int start_cyc = 0;
  logic [9:0] last_a = '0, last_b = '0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (div_start) begin
      start_cnt <= start_cnt + 1;
      start_cyc <= cyc + 1;
      last_a    <= div_a;
      last_b    <= div_b;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic nedge(); @(negedge clk); #1; endtask
  task automatic pedge(); @(posedge clk); #1; endtask

  task automatic push(input logic [9:0] a, input logic [9:0] b, input string nm);
    bit ok;
    ok = 0;
    in_a = a; in_b = b; in_valid = 1;
    for (int n = 0; n < 200 && !ok; n++) begin
      nedge();
      ok = in_ready;
      pedge();
    end
    in_valid = 0;
    if (!ok) chk({nm, "_push_timeout"}, 0, 1);
  endtask

  task automatic get_result(input int eq, input int est, input int hold, input bit inject,
                            input string nm, output int lat);
    bit seen;
    int q0;
    seen = 0;
    lat  = -1;
    for (int n = 0; n < 400 && !seen; n++) begin
      nedge();
      seen = out_valid;
    end
    if (!seen) begin
      chk({nm, "_valid_timeout"}, 0, 1);
    end else begin
      lat = cyc - start_cyc;
      chk({nm, "_q"}, int'(out_q), eq);
      chk({nm, "_status"}, int'(out_status), est);
      q0 = int'(out_q);
      if (inject) inj_req++;
      for (int h = 0; h < hold; h++) begin
        nedge();
        chk({nm, "_hold_valid"}, int'(out_valid), 1);
        chk({nm, "_hold_q"}, int'(out_q), q0);
        chk({nm, "_hold_status"}, int'(out_status), est);
      end
      out_ready = 1;
      pedge();
      out_ready = 0;
    end
  endtask

  // ---------------- random phase ----------------
  logic [11:0] sq[$];
  bit pv = 0, pr = 0;
  int pq = 0, pst = 0;

  task automatic rnd_step(input bit drive_rand);
    logic [11:0] e;
    if (drive_rand) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_a      = 10'($urandom);
      in_b      = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1)) : 10'($urandom_range(0, 40));
      out_ready = ($urandom_range(0, 3) != 0);
      m_lat     = $urandom_range(1, 6);
    end else begin
      in_valid  = 0;
      out_ready = 1;
    end
    nedge();
    if (in_valid && in_ready) sq.push_back(expect_res(in_a, in_b, 0));
    if (out_valid) begin
      if (pv && !pr) begin
        chk("rnd_hold_q", int'(out_q), pq);
        chk("rnd_hold_status", int'(out_status), pst);
      end
      if (out_ready) begin
        if (sq.size() == 0) begin
          chk("rnd_unexpected_result", 1, 0);
        end else begin
          e = sq.pop_front();
          chk("rnd_q", int'(out_q), int'(e[9:0]));
          chk("rnd_status", int'(out_status), int'(e[11:10]));
        end
      end
    end
    pv = out_valid; pr = out_ready; pq = int'(out_q); pst = int'(out_status);
    pedge();
  endtask

  // ---------------- main sequence ----------------
  typedef struct {
    logic [9:0] a;
    logic [9:0] b;
    logic [9:0] q;
    logic [1:0] st;
  } vec_t;

  vec_t vt[8];
  logic [9:0] fa[5];
  logic [9:0] fb[5];
  logic [9:0] fq[5];

  initial begin : main
    int lat, s0, s1;
    string nm;

    vt[0] = '{10'd100,  10'd5, 10'd20,   2'd0};
    vt[1] = '{10'd7,    10'd0, 10'h3FF,  2'd1};
    vt[2] = '{10'd600,  10'd1, 10'd600,  2'd2};
    vt[3] = '{10'd9,    10'd3, 10'd3,    2'd0};
    vt[4] = '{10'd1023, 10'd0, 10'h3FF,  2'd1};
    vt[5] = '{10'd511,  10'd1, 10'd511,  2'd0};
    vt[6] = '{10'd0,    10'd7, 10'd0,    2'd0};
    vt[7] = '{10'd1023, 10'd2, 10'd511,  2'd0};

    fa = '{10'd30, 10'd41, 10'd52, 10'd63, 10'd74};
    fb = '{10'd1,  10'd2,  10'd3,  10'd4,  10'd5};
    fq = '{10'd30, 10'd20, 10'd17, 10'd15, 10'd14};

    rst_n = 0; in_valid = 0; in_a = '0; in_b = '0; out_ready = 0;
    repeat (3) nedge();

    // reset values
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_fifo_level", int'(fifo_level), 0);
    chk("rst_div_start", int'(div_start), 0);
    chk("rst_div_a", int'(div_a), 0);
    chk("rst_div_b", int'(div_b), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_q", int'(out_q), 0);
    chk("rst_out_status", int'(out_status), 0);

    rst_n = 1;
    pedge();

    // table of single transactions
    for (int i = 0; i < 8; i++) begin
      nm    = $sformatf("vec%0d", i);
      m_mode = 0;
      m_lat  = (i == 0) ? 10 : 2 + i;
      s0     = start_cnt;
      push(vt[i].a, vt[i].b, nm);
      get_result(int'(vt[i].q), int'(vt[i].st), 2, 0, nm, lat);
      chk({nm, "_latency"}, lat, m_lat + 1);
      chk({nm, "_starts"}, start_cnt - s0, 1);
      chk({nm, "_div_a"}, int'(last_a), int'(vt[i].a));
      chk({nm, "_div_b"}, int'(last_b), int'(vt[i].b));
    end

    // divider never answers: timeout after TIMEOUT+1 wait cycles
    m_mode = 2;
    push(10'd55, 10'd11, "timeout");
    get_result(0, 3, 2, 0, "timeout", lat);
    chk("timeout_latency", lat, TIMEOUT + 2);

    // completion on the very cycle the counter reaches TIMEOUT
    m_mode = 0;
    m_lat  = TIMEOUT + 1;
    push(10'd200, 10'd8, "edge_to");
    get_result(25, 0, 0, 0, "edge_to", lat);
    chk("edge_to_latency", lat, TIMEOUT + 2);

    // dvz and ovf together, then flags pulsed in HOLD and in IDLE
    m_mode = 1;
    m_lat  = 4;
    push(10'd50, 10'd5, "both");
    get_result(10, 1, 3, 1, "both", lat);
    m_mode = 0;
    s0 = start_cnt;
    inj_req++;
    repeat (3) begin
      nedge();
      chk("idle_flags_out_valid", int'(out_valid), 0);
    end
    chk("idle_flags_no_start", start_cnt - s0, 0);
    pedge();

    // fill FIFO with consumer stalled
    out_ready = 0;
    m_lat = 2;
    for (int k = 0; k < 5; k++) begin
      push(fa[k], fb[k], $sformatf("fill%0d", k));
      nedge();
      chk($sformatf("fill%0d_level", k), int'(fifo_level), (k == 0) ? 1 : k);
      pedge();
    end
    nedge();
    chk("full_in_ready", int'(in_ready), 0);
    in_a = 10'd999; in_b = 10'd9; in_valid = 1;
    repeat (3) begin
      nedge();
      chk("full_blocked_level", int'(fifo_level), 4);
    end
    in_valid = 0;
    for (int k = 0; k < 5; k++)
      get_result(int'(fq[k]), 0, 0, 0, $sformatf("drain%0d", k), lat);

    // back-to-back: next start right after the handshake cycle
    m_lat = 2;
    push(10'd90, 10'd9, "b2b0");
    push(10'd80, 10'd4, "b2b1");
    s0 = 0;
    for (int n = 0; n < 100 && s0 == 0; n++) begin
      nedge();
      s0 = int'(out_valid);
    end
    chk("b2b0_valid", s0, 1);
    chk("b2b0_q", int'(out_q), 10);
    out_ready = 1;
    nedge();
    chk("b2b_start_after_handshake", int'(div_start), 1);
    chk("b2b_out_valid_dropped", int'(out_valid), 0);
    out_ready = 0;
    get_result(20, 0, 0, 0, "b2b1", lat);

    // randomized traffic against the expected-result queue
    pv = 0;
    for (int n = 0; n < 2000; n++) rnd_step(1);
    for (int n = 0; n < 400 && sq.size() != 0; n++) rnd_step(0);
    chk("rnd_drained", sq.size(), 0);
    in_valid = 0; out_ready = 0;

    // reset during WAIT with three entries queued
    m_mode = 0;
    m_lat  = 20;
    repeat (3) pedge();
    push(10'd11, 10'd1, "rw0");
    push(10'd12, 10'd2, "rw1");
    push(10'd13, 10'd3, "rw2");
    push(10'd14, 10'd4, "rw3");
    nedge();
    chk("rw_level_before", int'(fifo_level), 3);
    chk("rw_out_valid_before", int'(out_valid), 0);
    #2 rst_n = 0;
    #1;
    chk("rw_in_ready", int'(in_ready), 1);
    chk("rw_fifo_level", int'(fifo_level), 0);
    chk("rw_div_start", int'(div_start), 0);
    chk("rw_div_a", int'(div_a), 0);
    chk("rw_div_b", int'(div_b), 0);
    chk("rw_out_valid", int'(out_valid), 0);
    chk("rw_out_q", int'(out_q), 0);
    chk("rw_out_status", int'(out_status), 0);
    repeat (3) nedge();
    rst_n = 1;
    s1 = start_cnt;
    repeat (30) nedge();
    chk("rw_no_start_after", start_cnt - s1, 0);
    chk("rw_out_valid_after", int'(out_valid), 0);
    chk("rw_level_after", int'(fifo_level), 0);

    // push on the first rising edge after reset release
    rst_n = 0;
    nedge();
    m_lat = 3;
    in_a = 10'd100; in_b = 10'd4; in_valid = 1;
    rst_n = 1;
    pedge();
    in_valid = 0;
    nedge();
    chk("first_push_level", int'(fifo_level), 1);
    get_result(25, 0, 0, 0, "first_push", lat);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 Parameter DEPTH, 4, operand FIFO entries (power of 2, >=2).
REQ-002 Parameter TIMEOUT, 31, max WAIT cycles before timeout completion.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 in_valid  in  1  operand pair offered.
REQ-006 in_ready  out  1  FIFO can accept (not full).
REQ-007 in_a  in  10  dividend.
REQ-008 in_b  in  10  divisor.
REQ-009 div_start  out  1  one-cycle start pulse to divider.
REQ-010 div_a  out  10  dividend to divider.
REQ-011 div_b  out  10  divisor to divider.
REQ-012 div_q  in  10  divider quotient.
REQ-013 div_busy  in  1  divider computing.
REQ-014 div_valid  in  1  divider result valid.
REQ-015 div_dvz  in  1  divider divide-by-zero flag.
REQ-016 div_ovf  in  1  divider overflow flag.
REQ-017 out_valid  out  1  result held for consumer.
REQ-018 out_ready  in  1  consumer accepts result.
REQ-019 out_q  out  10  captured quotient.
REQ-020 out_status  out  2  00 ok, 01 dvz, 10 ovf, 11 timeout.
REQ-021 fifo_level  out  clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-022 Push when in_valid && in_ready; in_ready = (fifo_level != DEPTH); pointers wrap modulo DEPTH.
REQ-023 Simultaneous push and pop: level unchanged, both occur; push while full ignored (in_ready low).
REQ-024 FSM states IDLE, ISSUE, WAIT, HOLD.
REQ-025 IDLE -> ISSUE when FIFO non-empty and div_busy low; head pops into div_a/div_b registers on that edge.
REQ-026 ISSUE: div_start=1 exactly one cycle; next state WAIT; wait counter cleared to 0.
REQ-027 div_a/div_b stable from ISSUE through end of WAIT; div_start=0 in all other states.
REQ-028 WAIT: completion event = div_valid | div_dvz | div_ovf; on event capture out_q=div_q, status, go HOLD.
REQ-029 Status priority on simultaneous flags: dvz > ovf > ok; dvz/ovf completions capture out_q=div_q unchanged.
REQ-030 WAIT counter increments each cycle without event; counter==TIMEOUT without event -> HOLD, out_q=0, status 11.
REQ-031 Event on the same cycle counter reaches TIMEOUT: event wins (normal completion).
REQ-032 HOLD: out_valid=1, out_q/out_status stable until out_ready; on out_valid && out_ready -> IDLE (or directly ISSUE if FIFO non-empty and div_busy low).
REQ-033 Back-to-back throughput: with out_ready high and FIFO non-empty, next div_start occurs 1 cycle after handshake cycle.
REQ-034 FIFO accepts pushes in every state, including during WAIT/HOLD.
REQ-035 Divider flags outside WAIT are ignored.

Reset
REQ-036 rst_n low asynchronously: FSM IDLE, FIFO empty, fifo_level=0, in_ready=1, div_start=0, div_a=div_b=0, out_valid=0, out_q=0, out_status=00, wait counter 0.
REQ-037 Reset mid-operation discards FIFO contents and in-flight result; no div_start until rst_n high and a new push.
REQ-038 First push accepted on first rising edge after rst_n deasserts.

Verification
REQ-039 Push (a=100,b=5); divider model valid after 10 cycles with q=20 -> div_start one cycle, out_valid with out_q=20, status 00.
REQ-040 Push (a=7,b=0); model asserts dvz -> out_status 01, out_valid held until out_ready pulse.
REQ-041 Push 5 pairs with out_ready low, DEPTH=4 -> in_ready low after 4th accepted (one pops to divider, so 5th accepted), 6th blocked; all 5 results returned in order.
REQ-042 Model never responds -> after TIMEOUT+1 WAIT cycles out_valid, out_q=0, status 11.
REQ-043 Model asserts dvz and ovf same cycle -> status 01; flags pulsed during HOLD ignored.
REQ-044 rst_n low during WAIT with 3 entries queued -> all outputs at reset values immediately, fifo_level=0, no further div_start.
